// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output stage between
// N upstream streams, granting each winner a burst of up to BURST beats.
module stream_rr_arbiter #(
  parameter int N     = 3,
  parameter int DW    = 16,
  parameter int BURST = 4,
  parameter int CW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    up_valid,
  input  logic [N*DW-1:0] up_data,
  output logic [N-1:0]    up_ready,
  input  logic            down_ready,
  output logic            down_valid,
  output logic [DW-1:0]   down_data,
  output logic [N-1:0]    grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_reg;
  logic [N-1:0]  grant_reg;
  logic [IW-1:0] last_reg;
  logic [CW-1:0] beat_cnt_reg;
  logic          down_valid_reg;
  logic [DW-1:0] down_data_reg;

  logic [DW-1:0] lane_data [N];
  logic          out_free;

  // The output stage can accept a beat when empty or draining this cycle.
  assign out_free = ~down_valid_reg | down_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lane_data[gi] = up_data[gi*DW +: DW];
      assign up_ready[gi]  = grant_reg[gi] & out_free;
    end
  endgenerate

  // Scan last+1 .. last+N so the previously granted requester is checked last.
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  int            cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_reg) + k) % N;
      if (!pick_found && up_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  // While in GRANT, last_reg always holds the granted index.
  logic          cur_valid;
  logic [DW-1:0] cur_data;
  logic          xfer;
  logic          final_beat;
  logic          burst_end;

  assign cur_valid  = up_valid[last_reg];
  assign cur_data   = lane_data[last_reg];
  assign xfer       = (state_reg == GRANT) & cur_valid & out_free;
  assign final_beat = (beat_cnt_reg == CW'(BURST - 1));
  assign burst_end  = (state_reg == GRANT) & ((xfer & final_beat) | ~cur_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_reg       <= IW'(N - 1);
      beat_cnt_reg   <= '0;
      down_valid_reg <= 1'b0;
      down_data_reg  <= '0;
    end else begin
      if (xfer) begin
        down_valid_reg <= 1'b1;
        down_data_reg  <= cur_data;
      end else if (down_ready) begin
        down_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            state_reg    <= GRANT;
            grant_reg    <= N'(1) << pick_idx;
            beat_cnt_reg <= '0;
            last_reg     <= pick_idx;
          end
        end
        GRANT: begin
          if (burst_end) begin
            // Re-arbitrate in the same cycle so back-to-back bursts have no bubble.
            if (pick_found) begin
              grant_reg    <= N'(1) << pick_idx;
              beat_cnt_reg <= '0;
              last_reg     <= pick_idx;
            end else begin
              state_reg    <= IDLE;
              grant_reg    <= '0;
              beat_cnt_reg <= '0;
            end
          end else if (xfer) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

  assign down_valid = down_valid_reg;
  assign down_data  = down_data_reg;
  assign grant      = grant_reg;

endmodule
